// File: rtl/core_trace_pkg.sv
// Shared types for the trace-driven core model: opcodes, FSM states and the
// default-width instruction layout used by harnesses that load programs.
package core_trace_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_NOP   = 2'b10,
      OP_HALT  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DELAY = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   typedef struct packed {
      op_e                   op;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } instr_t;

   // A NOP of 0 cycles still costs one delay cycle, so the counter preload is max(n,1)-1.
   function automatic logic [15:0] nop_preload(input logic [15:0] cycles);
      return (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
   endfunction

endpackage

// File: rtl/trace_prog_mem.sv
// Simple DEPTH x WIDTH storage with synchronous write and asynchronous read;
// used for both the program memory and the per-instruction result buffer.
module trace_prog_mem #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage is deliberately not reset so programs survive a core reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/trace_core_driver.sv
// Trace-driven core model: replays a loaded instruction stream as read/write
// requests against one cache controller CPU port and records read results.
module trace_core_driver
   import core_trace_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 64,
   parameter int PC_W    = $clog2(DEPTH),
   parameter int INSTR_W = 2 + ADDR_W + DATA_W
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic               read,
   output logic               write,
   output logic [ADDR_W-1:0]  address,
   output logic [DATA_W-1:0]  write_data,
   input  logic               stall_cpu,
   input  logic [DATA_W-1:0]  fetched_data,
   output logic               busy,
   output logic               done,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W:0]      retired,
   input  logic [PC_W-1:0]    res_addr,
   output logic [DATA_W-1:0]  res_data
);

   localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};
   localparam logic [PC_W:0]   RET_ONE = {{PC_W{1'b0}}, 1'b1};
   localparam logic [PC_W:0]   RET_MAX = {1'b1, {PC_W{1'b0}}};

   state_e              state_r;
   logic [15:0]         cnt_r;
   logic [INSTR_W-1:0]  instr_s;
   op_e                 op_s;
   logic [ADDR_W-1:0]   instr_addr_s;
   logic [DATA_W-1:0]   instr_data_s;
   logic                prog_wen_s;
   logic                req_done_s;
   logic                res_wen_s;

   assign op_s         = op_e'(instr_s[INSTR_W-1 -: 2]);
   assign instr_addr_s = instr_s[DATA_W +: ADDR_W];
   assign instr_data_s = instr_s[DATA_W-1:0];

   // The program may only change while no run is in flight.
   assign prog_wen_s = prog_we && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign req_done_s = (state_r == ST_RUN) && (read || write) && !stall_cpu;
   assign res_wen_s  = req_done_s && read;

   trace_prog_mem #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_prog_mem (
      .clk   (clk),
      .we    (prog_wen_s),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc),
      .rdata (instr_s)
   );

   trace_prog_mem #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_result_mem (
      .clk   (clk),
      .we    (res_wen_s),
      .waddr (pc),
      .wdata (fetched_data),
      .raddr (res_addr),
      .rdata (res_data)
   );

   // Run-control FSM with all request and status outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 16'd0;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= {ADDR_W{1'b0}};
         write_data <= {DATA_W{1'b0}};
         busy       <= 1'b0;
         done       <= 1'b0;
         pc         <= {PC_W{1'b0}};
         retired    <= {(PC_W+1){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r <= ST_RUN;
                  pc      <= {PC_W{1'b0}};
                  retired <= {(PC_W+1){1'b0}};
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (read || write) begin
                  // Request outputs hold until the cache accepts; then one idle cycle follows.
                  if (!stall_cpu) begin
                     read  <= 1'b0;
                     write <= 1'b0;
                     if (retired != RET_MAX) begin
                        retired <= retired + RET_ONE;
                     end
                     if (pc == PC_LAST) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        pc <= pc + PC_ONE;
                     end
                  end
               end else begin
                  case (op_s)
                     OP_READ: begin
                        read    <= 1'b1;
                        address <= instr_addr_s;
                     end
                     OP_WRITE: begin
                        write      <= 1'b1;
                        address    <= instr_addr_s;
                        write_data <= instr_data_s;
                     end
                     OP_NOP: begin
                        state_r <= ST_DELAY;
                        cnt_r   <= nop_preload(instr_data_s[15:0]);
                     end
                     OP_HALT: begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end
                     default: begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end
                  endcase
               end
            end
            ST_DELAY: begin
               if (cnt_r == 16'd0) begin
                  if (pc == PC_LAST) begin
                     state_r <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     pc      <= pc + PC_ONE;
                  end
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               read    <= 1'b0;
               write   <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_core_driver.sv
// Directed self-checking bench for trace_core_driver with default parameters.
module tb_trace_core_driver;
   import core_trace_pkg::*;

   localparam int PC_W = 6;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [42:0] prog_data;
   logic        read;
   logic        write;
   logic [8:0]  address;
   logic [31:0] write_data;
   logic        stall_cpu;
   logic [31:0] fetched_data;
   logic        busy;
   logic        done;
   logic [5:0]  pc;
   logic [6:0]  retired;
   logic [5:0]  res_addr;
   logic [31:0] res_data;

   int total = 0;
   int bad   = 0;

   trace_core_driver dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .read         (read),
      .write        (write),
      .address      (address),
      .write_data   (write_data),
      .stall_cpu    (stall_cpu),
      .fetched_data (fetched_data),
      .busy         (busy),
      .done         (done),
      .pc           (pc),
      .retired      (retired),
      .res_addr     (res_addr),
      .res_data     (res_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic prog(input int idx, input op_e op, input logic [8:0] a, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = idx[PC_W-1:0];
      prog_data = {op, a, d};
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #12;
      total++; if ({read, write, busy, done} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {read, write, busy, done}); end
      total++; if (pc !== 6'd0) begin bad++; $display("FAIL rst_pc got=%0d exp=0", pc); end
      total++; if (retired !== 7'd0) begin bad++; $display("FAIL rst_retired got=%0d exp=0", retired); end
      total++; if ({address, write_data} !== 41'd0) begin bad++; $display("FAIL rst_req got=%h/%h exp=0/0", address, write_data); end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      bit ok;
      prog(0, OP_WRITE, 9'h005, 32'hDEADBEEF);
      prog(1, OP_READ,  9'h005, 32'h0);
      prog(2, OP_HALT,  9'h000, 32'h0);
      stall_cpu = 1'b0;
      fetched_data = 32'hDEADBEEF;
      pulse_start();
      total++; if ({busy, read, write} !== 3'b100) begin bad++; $display("FAIL wr_start got=%b exp=100", {busy, read, write}); end
      @(negedge clk);
      total++; if ({write, read, address, write_data} !== {1'b1, 1'b0, 9'h005, 32'hDEADBEEF}) begin
         bad++; $display("FAIL wr_req got=w%b r%b a=%h d=%h exp=w1 r0 a=005 d=deadbeef", write, read, address, write_data);
      end
      @(negedge clk);
      total++; if ({write, pc, retired} !== {1'b0, 6'd1, 7'd1}) begin
         bad++; $display("FAIL wr_complete got=w%b pc=%0d ret=%0d exp=w0 pc=1 ret=1", write, pc, retired);
      end
      @(negedge clk);
      total++; if ({read, write, address} !== {1'b1, 1'b0, 9'h005}) begin
         bad++; $display("FAIL rd_req got=r%b w%b a=%h exp=r1 w0 a=005", read, write, address);
      end
      wait_done(10, ok);
      total++; if (!ok) begin bad++; $display("FAIL wr_done_timeout got=0 exp=1"); end
      total++; if ({pc, retired, busy} !== {6'd2, 7'd2, 1'b0}) begin
         bad++; $display("FAIL wr_final got=pc=%0d ret=%0d busy=%b exp=pc=2 ret=2 busy=0", pc, retired, busy);
      end
      res_addr = 6'd1;
      #1;
      total++; if (res_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_result got=%h exp=deadbeef", res_data); end
   endtask

   task automatic test_stall();
      bit ok;
      fetched_data = 32'h12345678;
      stall_cpu = 1'b1;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++; if ({write, read, address, write_data, pc} !== {1'b1, 1'b0, 9'h005, 32'hDEADBEEF, 6'd0}) begin
            bad++; $display("FAIL stall_hold%0d got=w%b r%b a=%h d=%h pc=%0d exp=w1 r0 a=005 d=deadbeef pc=0", k, write, read, address, write_data, pc);
         end
      end
      stall_cpu = 1'b0;
      @(negedge clk);
      total++; if ({write, pc, retired} !== {1'b0, 6'd1, 7'd1}) begin
         bad++; $display("FAIL stall_release got=w%b pc=%0d ret=%0d exp=w0 pc=1 ret=1", write, pc, retired);
      end
      wait_done(10, ok);
      total++; if (!ok || retired !== 7'd2) begin bad++; $display("FAIL stall_final got=ok%b ret=%0d exp=ok1 ret=2", ok, retired); end
      res_addr = 6'd1;
      #1;
      total++; if (res_data !== 32'h12345678) begin bad++; $display("FAIL stall_result got=%h exp=12345678", res_data); end
   endtask

   task automatic test_nop();
      bit ok;
      prog(0, OP_NOP,  9'h000, 32'd4);
      prog(1, OP_READ, 9'h010, 32'h0);
      prog(2, OP_HALT, 9'h000, 32'h0);
      fetched_data = 32'hCAFE0001;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL nop_quiet%0d got=%b exp=00", k, {read, write}); end
      end
      @(negedge clk);
      total++; if ({read, address, pc} !== {1'b1, 9'h010, 6'd1}) begin
         bad++; $display("FAIL nop_read got=r%b a=%h pc=%0d exp=r1 a=010 pc=1", read, address, pc);
      end
      wait_done(10, ok);
      total++; if (!ok || retired !== 7'd1) begin bad++; $display("FAIL nop_final got=ok%b ret=%0d exp=ok1 ret=1", ok, retired); end
      res_addr = 6'd1;
      #1;
      total++; if (res_data !== 32'hCAFE0001) begin bad++; $display("FAIL nop_result got=%h exp=cafe0001", res_data); end
   endtask

   task automatic test_full_depth();
      bit ok;
      for (int i = 0; i < 64; i++) begin
         prog(i, OP_READ, 9'(i), 32'h0);
      end
      fetched_data = 32'h0BADF00D;
      pulse_start();
      wait_done(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_timeout got=0 exp=1"); end
      total++; if ({pc, retired} !== {6'd63, 7'd64}) begin
         bad++; $display("FAIL full_count got=pc=%0d ret=%0d exp=pc=63 ret=64", pc, retired);
      end
      repeat (3) @(negedge clk);
      total++; if ({pc, read, done} !== {6'd63, 1'b0, 1'b1}) begin
         bad++; $display("FAIL full_nowrap got=pc=%0d r%b done=%b exp=pc=63 r0 done=1", pc, read, done);
      end
      res_addr = 6'd63;
      #1;
      total++; if (res_data !== 32'h0BADF00D) begin bad++; $display("FAIL full_result got=%h exp=0badf00d", res_data); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      prog(0, OP_READ, 9'h033, 32'h0);
      prog(1, OP_HALT, 9'h000, 32'h0);
      stall_cpu = 1'b1;
      fetched_data = 32'h77777777;
      pulse_start();
      @(negedge clk);
      total++; if ({read, address} !== {1'b1, 9'h033}) begin bad++; $display("FAIL rmid_req got=r%b a=%h exp=r1 a=033", read, address); end
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      total++; if ({read, write, busy, done, pc} !== {4'b0000, 6'd0}) begin
         bad++; $display("FAIL rmid_async got=r%b w%b b%b d%b pc=%0d exp=0 0 0 0 0", read, write, busy, done, pc);
      end
      @(negedge clk);
      resetn = 1'b1;
      stall_cpu = 1'b0;
      for (int r = 0; r < 2; r++) begin
         pulse_start();
         wait_done(10, ok);
         total++; if (!ok || {pc, retired} !== {6'd1, 7'd1}) begin
            bad++; $display("FAIL rmid_rerun%0d got=ok%b pc=%0d ret=%0d exp=ok1 pc=1 ret=1", r, ok, pc, retired);
         end
         res_addr = 6'd0;
         #1;
         total++; if (res_data !== 32'h77777777) begin bad++; $display("FAIL rmid_result%0d got=%h exp=77777777", r, res_data); end
         @(negedge clk);
      end
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      prog_we = 1'b1;
      prog_addr = 6'd0;
      prog_data = {OP_WRITE, 9'h033, 32'h00000011};
      start = 1'b1;
      @(negedge clk);
      prog_we = 1'b0;
      start = 1'b0;
      @(negedge clk);
      total++; if ({write, read, address, write_data} !== {1'b1, 1'b0, 9'h033, 32'h00000011}) begin
         bad++; $display("FAIL same_edge got=w%b r%b a=%h d=%h exp=w1 r0 a=033 d=00000011", write, read, address, write_data);
      end
      wait_done(10, ok);
      total++; if (!ok || retired !== 7'd1) begin bad++; $display("FAIL same_edge_done got=ok%b ret=%0d exp=ok1 ret=1", ok, retired); end
   endtask

   task automatic test_prog_we_in_run();
      bit saw_write;
      bit saw_read;
      bit ok;
      prog(0, OP_NOP,  9'h000, 32'd20);
      prog(1, OP_READ, 9'h044, 32'h0);
      prog(2, OP_HALT, 9'h000, 32'h0);
      fetched_data = 32'h5A5A5A5A;
      for (int r = 0; r < 2; r++) begin
         saw_write = 1'b0;
         saw_read  = 1'b0;
         ok        = 1'b0;
         pulse_start();
         repeat (3) @(negedge clk);
         if (r == 0) begin
            prog(1, OP_WRITE, 9'h099, 32'hFFFFFFFF);
         end else begin
            @(negedge clk);
         end
         for (int i = 0; i < 60; i++) begin
            if (write === 1'b1) saw_write = 1'b1;
            if (read === 1'b1 && address === 9'h044) saw_read = 1'b1;
            if (done === 1'b1) begin
               ok = 1'b1;
               break;
            end
            @(negedge clk);
         end
         total++; if ({ok, saw_read, saw_write} !== 3'b110) begin
            bad++; $display("FAIL prog_in_run%0d got=done%b read044=%b write=%b exp=1 1 0", r, ok, saw_read, saw_write);
         end
         res_addr = 6'd1;
         #1;
         total++; if (res_data !== 32'h5A5A5A5A) begin bad++; $display("FAIL prog_in_run_result%0d got=%h exp=5a5a5a5a", r, res_data); end
         @(negedge clk);
      end
   endtask

   initial begin
      resetn       = 1'b0;
      start        = 1'b0;
      prog_we      = 1'b0;
      prog_addr    = 6'd0;
      prog_data    = 43'd0;
      stall_cpu    = 1'b0;
      fetched_data = 32'd0;
      res_addr     = 6'd0;
      test_reset();
      test_write_read();
      test_stall();
      test_nop();
      test_full_depth();
      test_reset_mid();
      test_prog_we_in_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
